// File: rtl/ex_multdiv_unit_pkg.sv
// Shared definitions for the EX-stage HI/LO multiply/divide unit:
// funct codes, FSM state encoding and the default datapath width.
package ex_multdiv_unit_pkg;

  localparam int DEFAULT_BUS_SIZE = 32;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FIXUP = 2'd2
  } state_t;

  // True for any of the eight instructions that touch HI/LO.
  function automatic logic is_hilo_funct(input logic [5:0] funct);
    case (funct)
      FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
      FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: is_hilo_funct = 1'b1;
      default:                                        is_hilo_funct = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ex_multdiv_unit_iter_core.sv
// Iteration engine for the multiply/divide unit. One accumulator pair
// serves both operations: for multiply acc_hi collects partial sums and
// acc_lo holds the shifting multiplier; for divide acc_hi is the partial
// remainder and acc_lo shifts the dividend out while the quotient shifts in.
module ex_multdiv_unit_iter_core
  import ex_multdiv_unit_pkg::*;
#(
  parameter int BUS_SIZE = DEFAULT_BUS_SIZE
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_load,
  input  logic                i_step,
  input  logic                i_is_div,
  input  logic [BUS_SIZE-1:0] i_opa,
  input  logic [BUS_SIZE-1:0] i_opb,
  output logic [BUS_SIZE-1:0] o_acc_hi,
  output logic [BUS_SIZE-1:0] o_acc_lo,
  output logic                o_last
);

  localparam int CNT_W = $clog2(BUS_SIZE) + 1;

  logic [BUS_SIZE-1:0] acc_hi_reg, acc_hi_next;
  logic [BUS_SIZE-1:0] acc_lo_reg, acc_lo_next;
  logic [BUS_SIZE-1:0] opnd_reg, opnd_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;

  logic [BUS_SIZE:0]   mul_sum;
  logic [BUS_SIZE:0]   div_shift;
  logic                div_ge;
  logic [BUS_SIZE-1:0] div_diff;

  // Load operands or perform one shift-add / restoring-subtract step.
  always_comb begin
    acc_hi_next = acc_hi_reg;
    acc_lo_next = acc_lo_reg;
    opnd_next   = opnd_reg;
    cnt_next    = cnt_reg;
    mul_sum     = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : '0);
    div_shift   = {acc_hi_reg, acc_lo_reg[BUS_SIZE-1]};
    div_ge      = (div_shift >= {1'b0, opnd_reg});
    div_diff    = BUS_SIZE'(div_shift - {1'b0, opnd_reg});
    if (i_load) begin
      acc_hi_next = '0;
      acc_lo_next = i_opa;
      opnd_next   = i_opb;
      cnt_next    = '0;
    end else if (i_step) begin
      if (i_is_div) begin
        acc_hi_next = div_ge ? div_diff : div_shift[BUS_SIZE-1:0];
        acc_lo_next = {acc_lo_reg[BUS_SIZE-2:0], div_ge};
      end else begin
        acc_hi_next = mul_sum[BUS_SIZE:1];
        acc_lo_next = {mul_sum[0], acc_lo_reg[BUS_SIZE-1:1]};
      end
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // Accumulator, operand and iteration counter registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      opnd_reg   <= '0;
      cnt_reg    <= '0;
    end else begin
      acc_hi_reg <= acc_hi_next;
      acc_lo_reg <= acc_lo_next;
      opnd_reg   <= opnd_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign o_acc_hi = acc_hi_reg;
  assign o_acc_lo = acc_lo_reg;
  assign o_last   = (cnt_reg == CNT_W'(BUS_SIZE - 1));

endmodule

// File: rtl/ex_multdiv_unit.sv
// EX-stage HI/LO multiply/divide unit: decode, FSM, sign handling,
// HI/LO registers and hazard stall. Optional macro MULTDIV_FAST_MUL_EN
// replaces the iterative multiply with a single-cycle product.
module ex_multdiv_unit
  import ex_multdiv_unit_pkg::*;
#(
  parameter int BUS_SIZE = DEFAULT_BUS_SIZE
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [5:0]          i_op,
  input  logic [5:0]          i_funct,
  input  logic [BUS_SIZE-1:0] i_bus_a,
  input  logic [BUS_SIZE-1:0] i_bus_b,
  output logic                o_busy,
  output logic                o_stall,
  output logic [BUS_SIZE-1:0] o_mf_data,
  output logic [BUS_SIZE-1:0] o_hi,
  output logic [BUS_SIZE-1:0] o_lo
);

  state_t state_reg, state_next;
  logic [BUS_SIZE-1:0] hi_reg, hi_next;
  logic [BUS_SIZE-1:0] lo_reg, lo_next;
  logic is_div_reg, neg_res_reg, neg_rem_reg, div_zero_reg;

  logic is_special, dec_mult, dec_div, dec_start, signed_op, sign_a, sign_b;
  logic [BUS_SIZE-1:0] mag_a, mag_b;
  logic core_load, core_step, core_last;
  logic [BUS_SIZE-1:0] core_hi, core_lo;

  assign is_special = (i_op == OP_SPECIAL);
  assign dec_mult   = is_special && (i_funct == FUNCT_MULT || i_funct == FUNCT_MULTU);
  assign dec_div    = is_special && (i_funct == FUNCT_DIV || i_funct == FUNCT_DIVU);
  assign signed_op  = (i_funct == FUNCT_MULT) || (i_funct == FUNCT_DIV);
  assign sign_a     = signed_op & i_bus_a[BUS_SIZE-1];
  assign sign_b     = signed_op & i_bus_b[BUS_SIZE-1];
  assign mag_a      = sign_a ? -i_bus_a : i_bus_a;
  assign mag_b      = sign_b ? -i_bus_b : i_bus_b;

`ifdef MULTDIV_FAST_MUL_EN
  // Multiplies complete at the start edge; only divides occupy the FSM.
  logic [2*BUS_SIZE-1:0] fast_mag, fast_prod;
  assign fast_mag  = (2*BUS_SIZE)'(mag_a) * (2*BUS_SIZE)'(mag_b);
  assign fast_prod = (sign_a ^ sign_b) ? -fast_mag : fast_mag;
  assign dec_start = dec_div;
`else
  assign dec_start = dec_mult | dec_div;
`endif

  ex_multdiv_unit_iter_core #(.BUS_SIZE(BUS_SIZE)) u_core (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (core_load),
    .i_step   (core_step),
    .i_is_div (is_div_reg),
    .i_opa    (mag_a),
    .i_opb    (mag_b),
    .o_acc_hi (core_hi),
    .o_acc_lo (core_lo),
    .o_last   (core_last)
  );

  // Next-state logic: start, iterate while enabled, fix up once.
  always_comb begin
    state_next = state_reg;
    core_load  = 1'b0;
    core_step  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (i_enable && dec_start) begin
          core_load  = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (i_enable) begin
          core_step = 1'b1;
          if (core_last) state_next = ST_FIXUP;
        end
      end
      ST_FIXUP: begin
        if (i_enable) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // HI/LO update: MT writes in IDLE, signed result write-back in FIXUP.
  always_comb begin
    hi_next = hi_reg;
    lo_next = lo_reg;
    if (i_enable && state_reg == ST_IDLE && is_special) begin
      if (i_funct == FUNCT_MTHI) hi_next = i_bus_a;
      if (i_funct == FUNCT_MTLO) lo_next = i_bus_a;
`ifdef MULTDIV_FAST_MUL_EN
      if (dec_mult) {hi_next, lo_next} = fast_prod;
`endif
    end else if (i_enable && state_reg == ST_FIXUP) begin
      if (is_div_reg) begin
        // Zero divisor: quotient all ones; remainder holds |rs| so the
        // dividend-sign fix restores rs exactly.
        lo_next = div_zero_reg ? '1 : (neg_res_reg ? -core_lo : core_lo);
        hi_next = neg_rem_reg ? -core_hi : core_hi;
      end else begin
        {hi_next, lo_next} = neg_res_reg ? -{core_hi, core_lo} : {core_hi, core_lo};
      end
    end
  end

  // FSM state and HI/LO registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg <= ST_IDLE;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  // Operation kind and result signs captured at the start edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      is_div_reg   <= 1'b0;
      neg_res_reg  <= 1'b0;
      neg_rem_reg  <= 1'b0;
      div_zero_reg <= 1'b0;
    end else if (core_load) begin
      is_div_reg   <= dec_div;
      neg_res_reg  <= sign_a ^ sign_b;
      neg_rem_reg  <= sign_a;
      div_zero_reg <= (i_bus_b == '0);
    end
  end

  assign o_busy    = (state_reg != ST_IDLE);
  assign o_stall   = o_busy && is_special && is_hilo_funct(i_funct);
  assign o_mf_data = (is_special && i_funct == FUNCT_MFHI) ? hi_reg :
                     (is_special && i_funct == FUNCT_MFLO) ? lo_reg : '0;
  assign o_hi      = hi_reg;
  assign o_lo      = lo_reg;

endmodule

// File: tb/tb_ex_multdiv_unit.sv
// Directed testbench for ex_multdiv_unit: reset, MT/MF, arithmetic vectors,
// stall behaviour, enable gaps and reset mid-operation.
module tb_ex_multdiv_unit;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;

`ifdef MULTDIV_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic [5:0]  i_op;
  logic [5:0]  i_funct;
  logic [31:0] i_bus_a;
  logic [31:0] i_bus_b;
  logic        o_busy;
  logic        o_stall;
  logic [31:0] o_mf_data;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  int total = 0;
  int bad   = 0;

  ex_multdiv_unit #(.BUS_SIZE(32)) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_enable  (i_enable),
    .i_op      (i_op),
    .i_funct   (i_funct),
    .i_bus_a   (i_bus_a),
    .i_bus_b   (i_bus_b),
    .o_busy    (o_busy),
    .o_stall   (o_stall),
    .o_mf_data (o_mf_data),
    .o_hi      (o_hi),
    .o_lo      (o_lo)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    i_op    = 6'h00;
    i_funct = f;
    i_bus_a = a;
    i_bus_b = b;
  endtask

  // Called at a negedge; returns at the negedge where o_busy has dropped.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    issue(f, a, b);
    @(posedge i_clk);
    @(negedge i_clk);
    issue(6'h00, 32'h0, 32'h0);
    cyc = 0;
    while (o_busy && cyc < 200) begin
      cyc++;
      @(negedge i_clk);
    end
  endtask

  task automatic test_reset();
    i_reset  = 1'b1;
    i_enable = 1'b0;
    issue(F_MFHI, 32'h0, 32'h0);
    repeat (2) @(negedge i_clk);
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", o_busy); end
    total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", o_stall); end
    total++; if (o_hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=0", o_hi); end
    total++; if (o_lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=0", o_lo); end
    total++; if (o_mf_data !== 32'h0) begin bad++; $display("FAIL reset_mf got=%h want=0", o_mf_data); end
    i_reset  = 1'b0;
    i_enable = 1'b1;
    issue(6'h00, 32'h0, 32'h0);
    @(negedge i_clk);
    $display("reset: busy=%b hi=%h lo=%h", o_busy, o_hi, o_lo);
  endtask

  task automatic test_mt_mf();
    issue(F_MTHI, 32'h1111_2222, 32'h0);
    @(posedge i_clk); @(negedge i_clk);
    total++; if (o_hi !== 32'h1111_2222) begin bad++; $display("FAIL mthi got=%h want=11112222", o_hi); end
    issue(F_MTLO, 32'h3333_4444, 32'h0);
    @(posedge i_clk); @(negedge i_clk);
    total++; if (o_lo !== 32'h3333_4444) begin bad++; $display("FAIL mtlo got=%h want=33334444", o_lo); end
    issue(F_MFHI, 32'h0, 32'h0); #1;
    total++; if (o_mf_data !== 32'h1111_2222) begin bad++; $display("FAIL mfhi got=%h want=11112222", o_mf_data); end
    issue(F_MFLO, 32'h0, 32'h0); #1;
    total++; if (o_mf_data !== 32'h3333_4444) begin bad++; $display("FAIL mflo got=%h want=33334444", o_mf_data); end
    issue(F_ADD, 32'h0, 32'h0); #1;
    total++; if (o_mf_data !== 32'h0) begin bad++; $display("FAIL mf_add got=%h want=0", o_mf_data); end
    i_op = 6'h08; i_funct = F_MFHI; #1;
    total++; if (o_mf_data !== 32'h0) begin bad++; $display("FAIL mf_nonspecial got=%h want=0", o_mf_data); end
    issue(6'h00, 32'h0, 32'h0);
    @(negedge i_clk);
    $display("mt_mf: hi=%h lo=%h", o_hi, o_lo);
  endtask

  task automatic test_arith();
    vec_t vecs[10];
    int   cyc;
    vecs[0] = '{F_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT};
    vecs[1] = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT};
    vecs[2] = '{F_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 33};
    vecs[3] = '{F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[4] = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
    vecs[5] = '{F_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        33};
    vecs[6] = '{F_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33};
    vecs[7] = '{F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MUL_LAT};
    vecs[8] = '{F_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 33};
    vecs[9] = '{F_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, MUL_LAT};
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, cyc);
      total++; if (cyc !== vecs[i].lat) begin bad++; $display("FAIL vec%0d busy_cycles got=%0d want=%0d", i, cyc, vecs[i].lat); end
      total++; if (o_hi !== vecs[i].hi) begin bad++; $display("FAIL vec%0d hi got=%h want=%h", i, o_hi, vecs[i].hi); end
      total++; if (o_lo !== vecs[i].lo) begin bad++; $display("FAIL vec%0d lo got=%h want=%h", i, o_lo, vecs[i].lo); end
      $display("arith vec%0d: funct=%h a=%h b=%h -> hi=%h lo=%h cycles=%0d",
               i, vecs[i].f, vecs[i].a, vecs[i].b, o_hi, o_lo, cyc);
    end
  endtask

  // Called at a negedge after the start edge; counts cycles while stalled.
  task automatic count_stall(output int cyc);
    cyc = 0;
    while (o_stall && cyc < 200) begin
      cyc++;
      @(negedge i_clk);
    end
  endtask

  task automatic test_stall();
    int cyc;
    // DIV then MFLO re-presented until the unit is idle
    issue(F_DIV, 32'd100, 32'd7);
    @(posedge i_clk); @(negedge i_clk);
    issue(F_MFLO, 32'h0, 32'h0); #1;
    count_stall(cyc);
    total++; if (cyc !== 33) begin bad++; $display("FAIL div_mflo_stall got=%0d want=33", cyc); end
    total++; if (o_mf_data !== 32'd14) begin bad++; $display("FAIL div_mflo_data got=%h want=0000000e", o_mf_data); end
    $display("stall div->mflo: stall_cycles=%0d mf=%h", cyc, o_mf_data);
    // MULT then MFLO
    issue(F_MULT, 32'd6, 32'd7);
    @(posedge i_clk); @(negedge i_clk);
    issue(F_MFLO, 32'h0, 32'h0); #1;
    count_stall(cyc);
    total++; if (cyc !== MUL_LAT) begin bad++; $display("FAIL mult_mflo_stall got=%0d want=%0d", cyc, MUL_LAT); end
    total++; if (o_mf_data !== 32'd42) begin bad++; $display("FAIL mult_mflo_data got=%h want=0000002a", o_mf_data); end
    $display("stall mult->mflo: stall_cycles=%0d mf=%h", cyc, o_mf_data);
    // Non-HI/LO instruction passes; MTHI during busy is held off
    issue(6'h00, 32'h0, 32'h0);
    @(negedge i_clk);
    issue(F_DIVU, 32'd100, 32'd7);
    @(posedge i_clk); @(negedge i_clk);
    issue(F_ADD, 32'h5, 32'h6); #1;
    total++; if (o_stall !== 1'b0 || o_busy !== 1'b1) begin bad++; $display("FAIL add_no_stall got=stall%b/busy%b want=stall0/busy1", o_stall, o_busy); end
    @(negedge i_clk);
    issue(F_MTHI, 32'hDEAD_BEEF, 32'h0); #1;
    total++; if (o_stall !== 1'b1) begin bad++; $display("FAIL mthi_busy_stall got=%b want=1", o_stall); end
    @(negedge i_clk);
    issue(6'h00, 32'h0, 32'h0);
    cyc = 0;
    while (o_busy && cyc < 200) begin cyc++; @(negedge i_clk); end
    total++; if (o_hi !== 32'd2) begin bad++; $display("FAIL mthi_busy_hi got=%h want=00000002", o_hi); end
    total++; if (o_lo !== 32'd14) begin bad++; $display("FAIL mthi_busy_lo got=%h want=0000000e", o_lo); end
    $display("stall add/mthi during divu: hi=%h lo=%h", o_hi, o_lo);
  endtask

  task automatic test_enable_gap();
    int  cyc;
    logic gap_busy;
    gap_busy = 1'b1;
    issue(F_DIVU, 32'd100, 32'd7);
    @(posedge i_clk); @(negedge i_clk);
    issue(6'h00, 32'h0, 32'h0);
    cyc = 0;
    while (o_busy && cyc < 200) begin
      cyc++;
      if (cyc == 10) i_enable = 1'b0;
      if (cyc == 15) i_enable = 1'b1;
      @(negedge i_clk);
      if (!i_enable && !o_busy) gap_busy = 1'b0;
    end
    i_enable = 1'b1;
    total++; if (gap_busy !== 1'b1) begin bad++; $display("FAIL gap_busy got=0 want=1"); end
    total++; if (cyc !== 38) begin bad++; $display("FAIL gap_cycles got=%0d want=38", cyc); end
    total++; if (o_lo !== 32'd14) begin bad++; $display("FAIL gap_lo got=%h want=0000000e", o_lo); end
    total++; if (o_hi !== 32'd2) begin bad++; $display("FAIL gap_hi got=%h want=00000002", o_hi); end
    $display("enable gap: cycles=%0d hi=%h lo=%h", cyc, o_hi, o_lo);
  endtask

  task automatic test_reset_mid();
    issue(F_DIVU, 32'd100, 32'd7);
    @(posedge i_clk); @(negedge i_clk);
    issue(6'h00, 32'h0, 32'h0);
    repeat (10) @(posedge i_clk);
    #2;
    i_reset = 1'b1;
    issue(F_MFHI, 32'h0, 32'h0);
    #1;
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", o_busy); end
    total++; if (o_hi !== 32'h0 || o_lo !== 32'h0) begin bad++; $display("FAIL rst_mid_hilo got=%h/%h want=0/0", o_hi, o_lo); end
    @(negedge i_clk);
    i_reset = 1'b0;
    @(posedge i_clk); @(negedge i_clk);
    total++; if (o_mf_data !== 32'h0 || o_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_mfhi got=%h busy=%b want=0 busy=0", o_mf_data, o_busy); end
    $display("reset mid-op: busy=%b hi=%h lo=%h mf=%h", o_busy, o_hi, o_lo, o_mf_data);
    issue(6'h00, 32'h0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_mt_mf();
    test_arith();
    test_stall();
    test_enable_gap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
